// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg                                                         |
// | Opcode, function-range, state, ALUOp and pc_src encodings shared by  |
// | the multi-cycle MIPS control sequencer.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_halt  = 6'b111111;

  localparam logic [5:0] c_func_min = 6'b100000;
  localparam logic [5:0] c_func_max = 6'b101110;
  localparam logic [5:0] c_func_mul = 6'b101101;
  localparam logic [5:0] c_func_div = 6'b101110;

  localparam logic [2:0] c_st_if     = 3'b000;
  localparam logic [2:0] c_st_id     = 3'b001;
  localparam logic [2:0] c_st_exe    = 3'b010;
  localparam logic [2:0] c_st_mem    = 3'b011;
  localparam logic [2:0] c_st_wb     = 3'b100;
  localparam logic [2:0] c_st_halt   = 3'b101;
  localparam logic [2:0] c_st_mdwait = 3'b110;

  localparam logic [4:0] c_aluop_none = 5'b00000;
  localparam logic [4:0] c_aluop_add  = 5'b00011;
  localparam logic [4:0] c_aluop_beq  = 5'b00100;
  localparam logic [4:0] c_aluop_bne  = 5'b01111;

  localparam logic [1:0] c_pcsrc_seq    = 2'b00;
  localparam logic [1:0] c_pcsrc_branch = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  function automatic logic is_muldiv_func(input logic [5:0] f);
    return (f == c_func_mul) || (f == c_func_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_op_decode                                                        |
// | Combinational op/func -> ALUOp decode with instruction legality.     |
// | Build option: MULDIV_EN makes mul/div functions legal.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [4:0] alu_op,
  output logic       legal,
  output logic       muldiv
);

  logic w_func_in_range;
  logic w_func_ok;

  assign w_func_in_range = (func >= c_func_min) && (func <= c_func_max);

`ifdef MULDIV_EN
  assign w_func_ok = w_func_in_range;
`else
  assign w_func_ok = w_func_in_range && !is_muldiv_func(func);
`endif

  always_comb begin
    alu_op = c_aluop_none;
    legal  = 1'b0;
    muldiv = 1'b0;
    case (op)
      c_op_rtype: begin
        if (w_func_ok) begin
          legal  = 1'b1;
          alu_op = func[4:0];
          muldiv = is_muldiv_func(func);
        end
      end
      c_op_addi, c_op_lw, c_op_sw: begin
        legal  = 1'b1;
        alu_op = c_aluop_add;
      end
      c_op_beq: begin
        legal  = 1'b1;
        alu_op = c_aluop_beq;
      end
      c_op_bne: begin
        legal  = 1'b1;
        alu_op = c_aluop_bne;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_ctrl                                                      |
// | Multi-cycle MIPS control sequencer: IF/ID/EXE/MEM/WB state machine   |
// | issuing per-state datapath strobes and the mul/div handshake.        |
// | Build option: MULDIV_EN enables the EXE -> MDWAIT mul/div path.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       alu_done,
  output logic [2:0] state,
  output logic       ir_wre,
  output logic       pc_wre,
  output logic [1:0] pc_src,
  output logic       reg_wre,
  output logic       reg_dst,
  output logic       mem_wre,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [4:0] alu_op,
  output logic       alu_start,
  output logic       halted
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [4:0] w_alu_op;
  logic       w_legal;
  logic       w_muldiv;
  logic       w_is_branch;
  logic       w_taken;
  logic       w_in_instr;

  alu_op_decode u_alu_op_decode (
    .op     (op),
    .func   (func),
    .alu_op (w_alu_op),
    .legal  (w_legal),
    .muldiv (w_muldiv)
  );

`ifndef MULDIV_EN
  logic w_unused;
  assign w_unused = alu_done | w_muldiv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_if;
    else     r_state <= w_next_state;
  end

  assign state       = r_state;
  assign w_is_branch = (op == c_op_beq) || (op == c_op_bne);
  assign w_taken     = (op == c_op_beq) ? zero : !zero;
  // Operand/ALU selects stay stable for every post-fetch state of the instruction.
  assign w_in_instr  = (r_state == c_st_id) || (r_state == c_st_exe) || (r_state == c_st_mem) ||
                       (r_state == c_st_wb) || (r_state == c_st_mdwait);

  always_comb begin
    w_next_state = c_st_if;
    ir_wre       = 1'b0;
    pc_wre       = 1'b0;
    pc_src       = c_pcsrc_seq;
    reg_wre      = 1'b0;
    reg_dst      = 1'b0;
    mem_wre      = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    alu_op       = c_aluop_none;
    alu_start    = 1'b0;
    halted       = 1'b0;

    case (r_state)
      c_st_if: begin
        ir_wre       = 1'b1;
        w_next_state = c_st_id;
      end
      c_st_id: begin
        if (op == c_op_j) begin
          pc_wre = 1'b1;
          pc_src = c_pcsrc_jump;
        end else if (op == c_op_halt) begin
          w_next_state = c_st_halt;
        end else if (w_legal) begin
          w_next_state = c_st_exe;
        end else begin
          pc_wre = 1'b1;
        end
      end
      c_st_exe: begin
        if (w_is_branch) begin
          pc_wre = 1'b1;
          pc_src = w_taken ? c_pcsrc_branch : c_pcsrc_seq;
        end else if ((op == c_op_lw) || (op == c_op_sw)) begin
          w_next_state = c_st_mem;
`ifdef MULDIV_EN
        end else if (w_muldiv) begin
          alu_start    = 1'b1;
          w_next_state = c_st_mdwait;
`endif
        end else begin
          w_next_state = c_st_wb;
        end
      end
      c_st_mem: begin
        if (op == c_op_sw) begin
          mem_wre = 1'b1;
          pc_wre  = 1'b1;
        end else begin
          mem_read     = 1'b1;
          w_next_state = c_st_wb;
        end
      end
      c_st_wb: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
      end
      c_st_halt: begin
        halted       = 1'b1;
        w_next_state = c_st_halt;
      end
`ifdef MULDIV_EN
      c_st_mdwait: begin
        w_next_state = alu_done ? c_st_wb : c_st_mdwait;
      end
`endif
      default: w_next_state = c_st_if;
    endcase

    if (w_in_instr) begin
      alu_op     = w_alu_op;
      reg_dst    = (op != c_op_rtype);
      alu_src    = (op == c_op_rtype) || w_is_branch;
      mem_to_reg = (op == c_op_lw);
    end

    // Reset forces every output quiet, including the IF fetch strobe.
    if (rst) begin
      ir_wre     = 1'b0;
      pc_wre     = 1'b0;
      pc_src     = c_pcsrc_seq;
      reg_wre    = 1'b0;
      reg_dst    = 1'b0;
      mem_wre    = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = c_aluop_none;
      alu_start  = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the MIPS CPU. It replaces the purely combinational per-instruction decode with a state machine that steps each instruction through IF/ID/EXE/MEM/WB. It issues per-state strobes to the PC, instruction register, register file, data memory and ALU. It sits between the instruction register (op/func source) and the shared datapath, and owns the handshake to the multi-cycle multiply/divide unit.

## Interface
Parameters:
- none (opcode, state and ALUOp encodings come from the package)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock, asynchronous and active-high
- op  in  6  instruction opcode from IR; stable from ID onward
- func  in  6  R-type function field from IR
- zero  in  1  ALU zero flag, valid in EXE
- alu_done  in  1  mul/div completion pulse
- state  out  3  current state
- ir_wre  out  1  latch instruction register
- pc_wre  out  1  update PC (last cycle of every instruction)
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- reg_wre  out  1  register file write
- reg_dst  out  1  0 = rd, 1 = rt
- mem_wre  out  1  data memory write
- mem_read  out  1  data memory read
- mem_to_reg  out  1  writeback selects memory data
- alu_src  out  1  1 = register operand B, 0 = sign-extended immediate
- alu_op  out  5  ALU operation code
- alu_start  out  1  one-cycle mul/div launch
- halted  out  1  processor stopped

## Operation
- States:
  - IF = 000
  - ID = 001
  - EXE = 010
  - MEM = 011
  - WB = 100
  - HALT = 101
  - MDWAIT = 110
  - Other codes recover to IF.
- IF: ir_wre = 1; next state is ID.
- ID, by op:
  - j (000010): pc_wre = 1, pc_src = 10, next IF.
  - halt (111111): next HALT.
  - R (000000) with legal func, addi (001000), lw (100011), sw (101011), beq (000100), bne (000101): next EXE.
  - Anything else (illegal) is a NOP: pc_wre = 1, pc_src = 00, next IF.
- Legal func is 100000..101110. In that range alu_op = func[4:0].
- Immediate-type alu_op: addi/lw/sw = 00011, beq = 00100, bne = 01111.
- EXE:
  - beq/bne: pc_wre = 1. pc_src = 01 when taken (beq: zero = 1; bne: zero = 0), otherwise 00. Next IF.
  - lw/sw: next MEM.
  - R/addi: next WB.
  - mul/div (func 101101/101110): see Configuration.
- MEM:
  - sw: mem_wre = 1, pc_wre = 1, next IF.
  - lw: mem_read = 1, next WB.
- WB: reg_wre = 1, pc_wre = 1, next IF. mem_to_reg = 1 only for lw.
- reg_dst = 0 for R-type, 1 otherwise.
- alu_src = 1 for R-type, beq and bne.
- HALT: halted = 1, all strobes 0, stays until rst.
- Outputs are combinational from state, op, func and zero. alu_op, reg_dst, alu_src and mem_to_reg are held valid from ID through the final state.

## Timing
- Reset (async): state = IF. While rst is high, every output is 0, including ir_wre and halted. The first ir_wre occurs in the first cycle after rst deasserts.
- Cycles per instruction:
  - j: 2
  - branch: 3
  - illegal: 2
  - R / addi / sw: 4
  - lw: 5
  - mul/div: 5 + N, where N is the number of MDWAIT cycles before alu_done
- pc_wre is asserted exactly once per instruction, in its final cycle. reg_wre and mem_wre are never asserted in the same cycle.
- alu_done is sampled only in MDWAIT. If alu_done is high on the first MDWAIT cycle, the next state is WB. alu_done in any other state is ignored.
- Reset mid-instruction: return to IF with no write strobe that cycle. The partially executed instruction is abandoned.

## Configuration
- MULDIV_EN defined:
  - EXE with func 101101/101110 asserts alu_start for that single cycle and moves to MDWAIT.
  - MDWAIT holds all strobes at 0 until alu_done, then moves to WB.
- MULDIV_EN undefined:
  - func 101101/101110 are illegal: NOP path from ID.
  - MDWAIT is unreachable and maps to IF.
  - alu_start is tied to 0.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode constants
  - func range bounds
  - state encoding
  - ALUOp constants
  - pc_src codes
- One combinational sub-module, alu_op_decode: op/func -> alu_op plus a legal flag. It honours MULDIV_EN for legality.
- The top level contains the state register, next-state logic and strobe decode.

## Test plan
- Reset held 3 cycles, then R add (func 100011) -> state IF, ID, EXE, WB; alu_op = 00011 from ID; reg_wre = 1 and pc_wre = 1 only in cycle 4.
- lw -> 5 cycles; mem_read = 1 in MEM, mem_to_reg = 1 with reg_wre in WB. Then sw -> mem_wre = 1 and pc_wre = 1 in MEM, no WB state.
- beq with zero = 1 -> pc_src = 01 in EXE. bne with zero = 1 -> pc_src = 00. j -> pc_src = 10 in ID.
- Divide (func 101110) with MULDIV_EN, alu_done after 7 MDWAIT cycles -> alu_start pulsed once in EXE, 12-cycle instruction. Repeat without MULDIV_EN -> 2-cycle NOP, alu_start never high.
- op 111111 -> HALT, halted = 1, no further ir_wre. Then rst -> IF.
- rst asserted during MEM of sw -> mem_wre never pulses, state = IF. Illegal op 010001 -> 2-cycle NOP.
